// File: rtl/conv_column_feeder_pkg.sv
// conv_column_feeder_pkg: shared defaults, memory map and FSM encoding for the column feeder.
package conv_column_feeder_pkg;
    localparam int BIT_LEN_D   = 8;
    localparam int ADDR_LEN_D  = 10;
    localparam int KERNEL_BASE = 0;
    localparam int IMG_BASE    = 3;
    typedef enum logic [2:0] {IDLE, CLR, KLOAD, ILOAD, FLUSH, DONE} state_t;
endpackage

// File: rtl/feeder_skid_reg.sv
// feeder_skid_reg: one-entry skid holding a BRAM word that returns while issue is stalled.
module feeder_skid_reg #(
    parameter int W = 25
) (
    input  logic         i_CLK,
    input  logic         i_reset,
    input  logic         i_stall,
    input  logic         i_valid,
    input  logic [W-1:0] i_data,
    output logic         o_valid,
    output logic [W-1:0] o_data
);
    logic         full;
    logic [W-1:0] hold_q;

    // Reads stop during a stall, so at most one word ever lands here.
    always_ff @(posedge i_CLK or negedge i_reset) begin
        if (!i_reset) begin
            full   <= 1'b0;
            hold_q <= '0;
        end else begin
            full <= i_stall && (full || i_valid);
            if (i_stall && i_valid && !full) hold_q <= i_data;
        end
    end

    assign o_valid = full || i_valid;
    assign o_data  = full ? hold_q : i_data;
endmodule

// File: rtl/conv_column_feeder.sv
// conv_column_feeder: streams kernel then image columns from a column BRAM into the 3x3 convolver
// and flags the cycles where the convolver holds a complete window.
module conv_column_feeder
    import conv_column_feeder_pkg::*;
#(
    parameter int BIT_LEN  = BIT_LEN_D,
    parameter int M_LEN    = 3,
    parameter int ADDR_LEN = ADDR_LEN_D
) (
    input  logic                   i_CLK,
    input  logic                   i_reset,
    input  logic                   i_start,
    input  logic [ADDR_LEN-1:0]    i_num_cols,
    input  logic                   i_stall,
    output logic [ADDR_LEN-1:0]    o_addr,
    output logic                   o_rd_en,
    input  logic [3*BIT_LEN-1:0]   i_mem_data,
    output logic [BIT_LEN-1:0]     o_dato0,
    output logic [BIT_LEN-1:0]     o_dato1,
    output logic [BIT_LEN-1:0]     o_dato2,
    output logic                   o_selecK_I,
    output logic                   o_valid,
    output logic                   o_conv_clr,
    output logic                   o_res_valid,
    output logic                   o_busy,
    output logic                   o_done,
    output logic                   o_err
);
    localparam int CW = ADDR_LEN + 1;

    state_t              state, state_nx;
    logic [ADDR_LEN-1:0] n_q, rd_idx, last_addr;
    logic                rd_en, flush_go, push, pend, pend_sel, src_valid, start_ok, short_n;
    logic [3*BIT_LEN:0]  src_data;
    logic [CW-1:0]       img_cnt;

    assign start_ok  = i_start && state == IDLE;
    assign short_n   = i_num_cols < ADDR_LEN'(M_LEN);
    assign last_addr = ADDR_LEN'(IMG_BASE - 1) + n_q;
    assign push      = !i_stall && (src_valid || flush_go);
    assign o_rd_en   = rd_en;
    assign o_addr    = rd_idx;

    always_ff @(posedge i_CLK or negedge i_reset) begin
        if (!i_reset) state <= IDLE;
        else          state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (i_start) state_nx = short_n ? DONE : CLR;
            CLR:     state_nx = KLOAD;
            KLOAD:   if (rd_en && rd_idx == ADDR_LEN'(IMG_BASE - 1)) state_nx = ILOAD;
            ILOAD:   if (rd_en && rd_idx == last_addr) state_nx = FLUSH;
            FLUSH:   if (flush_go) state_nx = DONE;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // The flush column waits until every fetched word, including a skidded one, has been issued.
    always_comb begin
        o_busy     = state inside {CLR, KLOAD, ILOAD, FLUSH};
        o_conv_clr = state == CLR;
        rd_en      = (state inside {CLR, KLOAD, ILOAD}) && !i_stall;
        flush_go   = state == FLUSH && !src_valid && !i_stall;
    end

    feeder_skid_reg #(.W(3*BIT_LEN + 1)) u_skid (
        .i_CLK   (i_CLK),
        .i_reset (i_reset),
        .i_stall (i_stall),
        .i_valid (pend),
        .i_data  ({pend_sel, i_mem_data}),
        .o_valid (src_valid),
        .o_data  (src_data)
    );

    always_ff @(posedge i_CLK or negedge i_reset) begin
        if (!i_reset) begin
            n_q         <= '0;
            rd_idx      <= '0;
            pend        <= 1'b0;
            pend_sel    <= 1'b0;
            o_valid     <= 1'b0;
            o_selecK_I  <= 1'b0;
            o_dato0     <= '0;
            o_dato1     <= '0;
            o_dato2     <= '0;
            img_cnt     <= '0;
            o_res_valid <= 1'b0;
            o_done      <= 1'b0;
            o_err       <= 1'b0;
        end else begin
            if (start_ok) begin
                n_q   <= i_num_cols;
                o_err <= short_n;
            end
            rd_idx   <= o_busy ? rd_idx + ADDR_LEN'(rd_en) : ADDR_LEN'(KERNEL_BASE);
            pend     <= rd_en;
            pend_sel <= rd_idx >= ADDR_LEN'(IMG_BASE);
            o_valid  <= push;
            if (push) {o_selecK_I, o_dato2, o_dato1, o_dato0} <= flush_go ? {1'b1, {3*BIT_LEN{1'b0}}} : src_data;
            // Image push j completes the window of columns j-3..j-1 once j reaches the kernel size.
            img_cnt     <= state == CLR ? '0 : img_cnt + CW'(o_valid && o_selecK_I);
            o_res_valid <= o_valid && o_selecK_I && img_cnt >= CW'(M_LEN);
            o_done      <= state == DONE;
        end
    end
endmodule

// File: tb/tb_conv_column_feeder.sv
// tb_conv_column_feeder: directed frames against a queue-based column-stream model of the feeder.
module tb_conv_column_feeder;
    localparam int BL = 8;
    localparam int AL = 10;
    localparam int DW = 3 * BL;

    typedef struct packed {
        logic          sel;
        logic [DW-1:0] d;
    } col_t;

    logic          clk = 0, rst_n = 0, start = 0, stall = 0;
    logic [AL-1:0] num = '0;
    logic [AL-1:0] o_addr;
    logic          o_rd_en;
    logic [DW-1:0] rdata = '0;
    logic [BL-1:0] d0, d1, d2;
    logic          sel, valid, clr, res, busy, done, err;
    logic [DW-1:0] mem [0:1023];
    logic [DW-1:0] kern_h [0:2];
    logic [DW-1:0] img_h [0:63];
    col_t          expq[$];
    col_t          last_col;
    int            checks = 0, failures = 0, cyc = 0;
    int            clr_n, clr_cyc, val_n, val_first, val_last, res_n, done_n, done_cyc, rd_n, busy_n, img_j, k_n;
    logic          exp_res = 0;
    bit            sum_mode = 0;

    conv_column_feeder dut (
        .i_CLK       (clk),
        .i_reset     (rst_n),
        .i_start     (start),
        .i_num_cols  (num),
        .i_stall     (stall),
        .o_addr      (o_addr),
        .o_rd_en     (o_rd_en),
        .i_mem_data  (rdata),
        .o_dato0     (d0),
        .o_dato1     (d1),
        .o_dato2     (d2),
        .o_selecK_I  (sel),
        .o_valid     (valid),
        .o_conv_clr  (clr),
        .o_res_valid (res),
        .o_busy      (busy),
        .o_done      (done),
        .o_err       (err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (o_rd_en) rdata <= mem[o_addr];
    end

    task automatic chk(input string name, input longint act, input longint exp_v);
        checks++;
        if (act != exp_v) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp_v);
        end
    endtask

    function automatic int wsum(input int j);
        int s = 0;
        for (int c = 0; c < 3; c++)
            for (int r = 0; r < 3; r++)
                s += int'(kern_h[c][r*BL +: BL]) * int'(img_h[j-3+c][r*BL +: BL]);
        return s;
    endfunction

    always @(negedge clk) begin : mon
        col_t cur, e;
        if (rst_n) begin
            cur = '{sel: sel, d: {d2, d1, d0}};
            if (clr) begin clr_n++; clr_cyc = cyc; end
            if (o_rd_en) rd_n++;
            if (busy) busy_n++;
            if (done) begin done_n++; done_cyc = cyc; end
            chk("res_valid", res, exp_res);
            if (res) begin
                res_n++;
                if (sum_mode) chk("window_sum", wsum(img_j - 1), 9);
            end
            exp_res = 0;
            if (valid) begin
                if (val_n == 0) val_first = cyc;
                val_last = cyc;
                val_n++;
                if (expq.size() == 0) chk("extra_column", 1, 0);
                else begin
                    e = expq.pop_front();
                    chk("col_data", cur.d, e.d);
                    chk("col_sel", cur.sel, e.sel);
                end
                if (cur.sel) begin
                    if (img_j < 64) img_h[img_j] = cur.d;
                    exp_res = img_j >= 3;
                    img_j++;
                end else if (k_n < 3) begin
                    kern_h[k_n] = cur.d;
                    k_n++;
                end
                last_col = cur;
            end else if (val_n > 0) chk("hold", cur, last_col);
        end
    end

    task automatic fill(input bit ones);
        logic [7:0] b;
        for (int a = 0; a < 1024; a++) begin
            b = a[7:0];
            mem[a] = ones ? 24'h010101 : {b, b, b};
        end
    endtask

    task automatic frame_begin(input int n);
        clr_n = 0; val_n = 0; res_n = 0; done_n = 0; rd_n = 0; busy_n = 0; img_j = 0; k_n = 0;
        clr_cyc = -1; done_cyc = -1; val_first = -1; val_last = -1; exp_res = 0;
        expq.delete();
        if (n >= 3) begin
            for (int a = 0; a < n + 3; a++) expq.push_back('{sel: (a >= 3), d: mem[a]});
            expq.push_back('{sel: 1'b1, d: '0});
        end
    endtask

    task automatic run_frame(input int n, input bit do_stall, input bit do_restart);
        int s, x;
        bit stalled = 0;
        frame_begin(n);
        x = do_stall ? 3 : 0;
        @(negedge clk);
        start = 1; num = n[AL-1:0]; s = cyc;
        for (int t = 0; t < 300 && done_n == 0; t++) begin
            @(negedge clk);
            start = do_restart && t == 6;
            if (start) num = 7;
            if (do_stall && !stalled && o_rd_en && o_addr == AL'(4)) begin
                @(posedge clk); #1 stall = 1;
                repeat (3) @(posedge clk);
                #1 stall = 0;
                stalled = 1;
            end
        end
        start = 0;
        if (done_n == 0) chk("done_timeout", 0, 1);
        repeat (2) @(negedge clk);
        chk("done_count", done_n, 1);
        if (n < 3) begin
            chk("err_set", err, 1);
            chk("err_done_cycle", done_cyc, s + 2);
            chk("err_valid_count", val_n, 0);
            chk("err_rd_count", rd_n, 0);
            chk("err_clr_count", clr_n, 0);
            chk("err_busy_cycles", busy_n, 0);
        end else begin
            chk("err_clear", err, 0);
            chk("clr_cycle", clr_cyc, s + 1);
            chk("clr_count", clr_n, 1);
            chk("first_valid", val_first, s + 3);
            chk("valid_count", val_n, n + 4);
            chk("valid_gap", val_last - val_first + 1 - val_n, x);
            chk("rd_count", rd_n, n + 3);
            chk("res_count", res_n, n - 2);
            chk("busy_cycles", busy_n, n + 5 + x);
            chk("done_cycle", done_cyc, s + n + 7 + x);
            chk("queue_empty", expq.size(), 0);
        end
    endtask

    task automatic reset_mid_frame();
        int t;
        frame_begin(5);
        @(negedge clk);
        start = 1; num = 5;
        @(negedge clk);
        start = 0;
        for (t = 0; t < 50 && !(o_rd_en && o_addr == AL'(5)); t++) @(negedge clk);
        if (t == 50) chk("reset_wait_timeout", 0, 1);
        #2 rst_n = 0;
        val_n = 0; exp_res = 0;
        #1 chk("async_reset_outputs", {o_addr, o_rd_en, d0, d1, d2, sel, valid, clr, res, busy, done, err}, 0);
        chk("abort_no_done", done_n, 0);
        @(negedge clk);
        chk("reset_held_busy", busy, 0);
        rst_n = 1;
    endtask

    initial begin
        fill(0);
        #1 chk("reset_outputs", {o_addr, o_rd_en, d0, d1, d2, sel, valid, clr, res, busy, done, err}, 0);
        repeat (3) @(negedge clk);
        rst_n = 1;
        run_frame(4, 0, 0);
        run_frame(2, 0, 0);
        repeat (5) @(negedge clk);
        chk("err_sticky", err, 1);
        run_frame(6, 1, 0);
        run_frame(5, 0, 1);
        reset_mid_frame();
        run_frame(5, 0, 0);
        fill(1);
        sum_mode = 1;
        run_frame(5, 0, 0);
        sum_mode = 0;
        run_frame(3, 0, 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
